softmax_avg_argmax: RTL and testbench
=====================================

Name: softmax_avg_argmax

Overview:
- Post-processing stage directly downstream of MLP_HEAD_SOFTMAX_STEP / SOFTMAX_DIVIDE_STEP; implements SOFTMAX_AVERAGING_STEP, SOFTMAX_AVERAGE_ARGMAX_STEP and SOFTMAX_RETIRE_STEP.
- Reads the current per-class softmax vector and up to N_AVG-1 previous vectors from intermediate-result memory, then writes the per-class averages.
- Tracks the argmax over the averages to produce the sleep stage.
- Shifts the history buffer at PREV_SOFTMAX_OUTPUT_MEM so the next inference sees this one.

Parameters:
- NUM_CLASSES, 5, number of sleep stages (NUM_SLEEP_STAGES).
- N_AVG, 3, samples averaged (NUM_SAMPLES_OUT_AVG).
- W, 9, data word width (N_STO_INT_RES); signed, Q1.7 (1.0 = 128).
- ADDR_W, 16, intermediate-result address width (IntResAddr_t).
- CUR_BASE, 32, current softmax base (MLP_HEAD_DENSE_2_OUT_MEM).
- AVG_BASE, 0, average output base (SOFTMAX_AVG_SUM_MEM).
- PREV_BASE, 57334, history base (PREV_SOFTMAX_OUTPUT_MEM); row k of class c is at PREV_BASE + k*NUM_CLASSES + c.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins processing; ignored unless in IDLE.
- hist_clear  in  1  one-cycle pulse; zeroes the valid-history counter; honoured only in IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_rd_en  out  1  read strobe; mem_rd_data is valid on the next cycle.
- mem_rd_data  in  W  read data.
- mem_wr_en  out  1  write strobe; writes mem_wr_data to mem_addr in the same cycle.
- mem_wr_data  out  W  write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at completion.
- sleep_stage  out  3  argmax class; held until the next done.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - hist_cnt = 0. hist_cnt counts valid previous rows and saturates at N_AVG-1.
  - Argmax registers are cleared.
- Samples per class: n = 1 + hist_cnt, latched at start.
- States and transitions:
  - IDLE -> AVG_RD on start.
  - AVG_RD issues n reads on consecutive cycles: CUR_BASE+c, then PREV_BASE+c, then PREV_BASE+NUM_CLASSES+c. Each read's data is accumulated into a signed (W+2)-bit sum on the following cycle.
  - AVG_DRAIN lasts 1 cycle and accumulates the last datum.
  - AVG_WR (1 cycle):
    - Computes avg = (sum * R[n]) >>> 16, arithmetic shift, truncated to W bits. R[1]=65536, R[2]=32768, R[3]=21846.
    - Writes avg to AVG_BASE+c.
    - If c==0 or avg > best (strict), sets best = avg and best_idx = c. Ties keep the lower index.
    - If c < NUM_CLASSES-1, increments c and returns to AVG_RD; otherwise goes to RET_RD.
  - RET_RD / RET_WR alternate, one copy per pair (2 cycles per copy):
    - Phase 1, for c = 0..4: row1[c] <- row0[c]. Skipped when N_AVG < 3.
    - Phase 2, for c = 0..4: row0[c] <- current[c].
    - Phase 1 always completes before phase 2 starts.
  - DONE (1 cycle): done=1, sleep_stage=best_idx, hist_cnt = min(hist_cnt+1, N_AVG-1). Then returns to IDLE.
- Latency: start accepted at cycle 0 gives done at cycle 5*(n+2) + 20 + 1, i.e. 36/41/46 for n = 1/2/3.
- Memory access rules:
  - mem_rd_en and mem_wr_en are never high in the same cycle.
  - mem_addr is driven 0 when both strobes are low.
- Arithmetic:
  - Sums use sign extension.
  - Max input sum 384 maps to avg 128; no saturation is needed for in-range Q1.7 inputs.
- Boundary conditions:
  - start while busy: ignored.
  - hist_clear and start in the same cycle in IDLE: clear applies first, so n = 1.
  - rst mid-operation: immediate return to IDLE; outputs and hist_cnt reset. Partial memory writes are not rolled back.

Test Plan:
- Fresh reset, current = {10,100,20,5,0}, start -> averages written equal the inputs; sleep_stage=1; done at cycle 36; hist_cnt=1; row0 = {10,100,20,5,0}.
- Second inference, current = {128,0,0,0,0}, row0 = {0,128,0,0,0} -> avg = {64,64,0,0,0}; tie resolves to sleep_stage=0; done at cycle 41.
- Third inference with rows {30,30,30,30,30}, {60,0,0,0,90}, current {0,90,0,0,120} -> avg = {30,40,10,10,80}; sleep_stage=4; done at cycle 46; afterwards row1=row0(old) and row0=current.
- All-128 inputs with n=3 -> every avg = 128; no overflow; sleep_stage=0.
- start asserted while busy, and hist_clear mid-run -> both ignored; a later hist_clear plus start in IDLE gives n=1.
- rst asserted at cycle 20 of a run -> busy=0, done never pulses, sleep_stage=0, hist_cnt=0.

Source files
------------

// File: rtl/softmax_avg_argmax.sv
// softmax_avg_argmax: averages current and previous softmax vectors, tracks the argmax stage and shifts the history rows.
module softmax_avg_argmax #(
  parameter int NUM_CLASSES = 5,
  parameter int N_AVG = 3,
  parameter int W = 9,
  parameter int ADDR_W = 16,
  parameter int CUR_BASE = 32,
  parameter int AVG_BASE = 0,
  parameter int PREV_BASE = 57334
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              hist_clear,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [W-1:0]      mem_rd_data,
  output logic              mem_wr_en,
  output logic [W-1:0]      mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        sleep_stage
);
  localparam int NW = $clog2(N_AVG + 1);
  localparam int CW = $clog2(NUM_CLASSES);
  localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);
  typedef enum logic [2:0] {IDLE, AVG_RD, AVG_DRAIN, AVG_WR, RET_RD, RET_WR, DONE_S} state_t;
  state_t state;
  logic [CW-1:0] c, best_idx;
  logic [NW-1:0] k, n, hist_cnt;
  logic ph, acc_v;
  logic signed [W+1:0] sum;
  logic signed [W-1:0] best, avg;
  logic signed [17:0] r;
  logic signed [W+19:0] prod;
  logic [ADDR_W-1:0] ca, rd_addr;
  always_comb begin
    r = (n == NW'(1)) ? 18'sd65536 : (n == NW'(2)) ? 18'sd32768 : 18'sd21846;
    prod = sum * r;
    avg = W'(prod >>> 16);
    ca = ADDR_W'(c);
    rd_addr = (k == '0) ? ADDR_W'(CUR_BASE) + ca
            : ADDR_W'(PREV_BASE) + ADDR_W'(k - 1'b1) * ADDR_W'(NUM_CLASSES) + ca;
    mem_rd_en = (state == AVG_RD) || (state == RET_RD);
    mem_wr_en = (state == AVG_WR) || (state == RET_WR);
    mem_addr = (state == AVG_RD) ? rd_addr
             : (state == RET_RD) ? (ph ? ADDR_W'(CUR_BASE) + ca : ADDR_W'(PREV_BASE) + ca)
             : (state == AVG_WR) ? ADDR_W'(AVG_BASE) + ca
             : (state == RET_WR) ? (ph ? ADDR_W'(PREV_BASE) + ca : ADDR_W'(PREV_BASE) + ADDR_W'(NUM_CLASSES) + ca)
             : '0;
    mem_wr_data = (state == AVG_WR) ? avg : (state == RET_WR) ? mem_rd_data : '0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      c <= '0;
      k <= '0;
      n <= '0;
      hist_cnt <= '0;
      ph <= 1'b0;
      acc_v <= 1'b0;
      sum <= '0;
      best <= '0;
      best_idx <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      sleep_stage <= '0;
    end else begin
      done <= 1'b0;
      acc_v <= (state == AVG_RD);
      if (acc_v) sum <= sum + {{2{mem_rd_data[W-1]}}, mem_rd_data};
      case (state)
        IDLE: begin
          if (hist_clear) hist_cnt <= '0;
          if (start) begin
            state <= AVG_RD;
            busy <= 1'b1;
            c <= '0;
            k <= '0;
            sum <= '0;
            n <= hist_clear ? NW'(1) : hist_cnt + 1'b1;
          end
        end
        AVG_RD: begin
          k <= (k == n - 1'b1) ? '0 : k + 1'b1;
          if (k == n - 1'b1) state <= AVG_DRAIN;
        end
        AVG_DRAIN: state <= AVG_WR;
        AVG_WR: begin
          sum <= '0;
          if (c == '0 || avg > best) begin
            best <= avg;
            best_idx <= c;
          end
          c <= (c == LAST) ? '0 : c + 1'b1;
          ph <= (N_AVG < 3);
          state <= (c == LAST) ? RET_RD : AVG_RD;
        end
        RET_RD: state <= RET_WR;
        RET_WR: begin
          c <= (c == LAST) ? '0 : c + 1'b1;
          if (c == LAST && !ph) ph <= 1'b1;
          state <= (c == LAST && ph) ? DONE_S : RET_RD;
        end
        DONE_S: begin
          done <= 1'b1;
          busy <= 1'b0;
          sleep_stage <= 3'(best_idx);
          hist_cnt <= (hist_cnt == NW'(N_AVG - 1)) ? hist_cnt : hist_cnt + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_softmax_avg_argmax.sv
// tb_softmax_avg_argmax: directed scoreboard bench for softmax_avg_argmax.
module tb_softmax_avg_argmax;
  localparam int CUR = 32, ROW0 = 57334, ROW1 = 57339;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, hist_clear = 1'b0;
  logic [15:0] mem_addr;
  logic mem_rd_en, mem_wr_en, busy, done;
  logic [8:0] mem_rd_data, mem_wr_data;
  logic [2:0] sleep_stage;
  logic signed [8:0] mem [0:65535];
  typedef struct {logic [15:0] a; logic [8:0] d;} wr_t;
  wr_t q[$];
  int checks = 0, failures = 0;
  int hn = 0;

  softmax_avg_argmax dut (
    .clk(clk), .rst(rst), .start(start), .hist_clear(hist_clear),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .sleep_stage(sleep_stage)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rw_excl", {31'b0, mem_rd_en & mem_wr_en}, 32'd0);
      if (!mem_rd_en && !mem_wr_en) chk("idle_addr", {16'b0, mem_addr}, 32'd0);
      if (mem_wr_en) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $error("FAIL wr_extra got_addr=%0d exp=none", mem_addr);
        end else begin
          wr_t e;
          e = q.pop_front();
          chk("wr_addr", {16'b0, mem_addr}, {16'b0, e.a});
          chk("wr_data", {23'b0, mem_wr_data}, {23'b0, e.d});
        end
      end
    end
  end

  task automatic setrow(input int base, input int v0, input int v1, input int v2, input int v3, input int v4);
    mem[base] <= 9'(v0);
    mem[base+1] <= 9'(v1);
    mem[base+2] <= 9'(v2);
    mem[base+3] <= 9'(v3);
    mem[base+4] <= 9'(v4);
  endtask

  // Expected writes: five averages, then row1 <= row0, then row0 <= current.
  task automatic model(input int n);
    for (int c = 0; c < 5; c++) begin
      int s, r, a;
      wr_t e;
      s = 0;
      for (int k = 0; k < n; k++) s += (k == 0) ? int'(mem[CUR+c]) : int'(mem[ROW0+(k-1)*5+c]);
      r = (n == 1) ? 65536 : (n == 2) ? 32768 : 21846;
      a = (s * r) >>> 16;
      e.a = 16'(c);
      e.d = a[8:0];
      q.push_back(e);
    end
    for (int c = 0; c < 5; c++) begin
      wr_t e;
      e.a = 16'(ROW1 + c);
      e.d = mem[ROW0+c];
      q.push_back(e);
    end
    for (int c = 0; c < 5; c++) begin
      wr_t e;
      e.a = 16'(ROW0 + c);
      e.d = mem[CUR+c];
      q.push_back(e);
    end
  endtask

  task automatic run(input string tag, input bit clr, input int inj, input int exp_lat, input int exp_stage);
    int cnt, n;
    @(negedge clk);
    n = clr ? 1 : hn + 1;
    model(n);
    start = 1'b1;
    hist_clear = clr;
    @(posedge clk);
    #1;
    start = 1'b0;
    hist_clear = 1'b0;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    cnt = 0;
    while (cnt < 200) begin
      @(posedge clk);
      #1;
      cnt++;
      start = 1'b0;
      hist_clear = 1'b0;
      if (done) break;
      if (cnt == inj) begin
        start = 1'b1;
        hist_clear = 1'b1;
      end
    end
    chk({tag, "_lat"}, cnt, exp_lat);
    chk({tag, "_stage"}, {29'b0, sleep_stage}, exp_stage);
    chk({tag, "_pending"}, q.size(), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_done_pulse"}, {30'b0, done, busy}, 32'd0);
    hn = (hn + 1 > 2) ? 2 : hn + 1;
  endtask

  initial begin
    for (int i = 0; i < 48; i++) mem[i] <= '0;
    for (int i = ROW0; i < ROW0 + 10; i++) mem[i] <= '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_stage", {29'b0, sleep_stage}, 32'd0);
    chk("rst_strobes", {30'b0, mem_rd_en, mem_wr_en}, 32'd0);
    rst = 1'b0;
    setrow(CUR, 10, 100, 20, 5, 0);
    run("t1", 1'b0, 0, 36, 1);
    chk("t1_row0", {23'b0, mem[ROW0+1]}, 32'd100);
    setrow(CUR, 128, 0, 0, 0, 0);
    setrow(ROW0, 0, 128, 0, 0, 0);
    run("t2", 1'b0, 0, 41, 0);
    setrow(CUR, 0, 90, 0, 0, 120);
    setrow(ROW0, 60, 0, 0, 0, 90);
    setrow(ROW1, 30, 30, 30, 30, 30);
    run("t3", 1'b0, 0, 46, 4);
    chk("t3_row1", {23'b0, mem[ROW1+4]}, 32'd90);
    chk("t3_row0", {23'b0, mem[ROW0+4]}, 32'd120);
    chk("t3_avg4", {23'b0, mem[4]}, 32'd80);
    setrow(CUR, 128, 128, 128, 128, 128);
    setrow(ROW0, 128, 128, 128, 128, 128);
    setrow(ROW1, 128, 128, 128, 128, 128);
    run("t4", 1'b0, 0, 46, 0);
    chk("t4_avg2", {23'b0, mem[2]}, 32'd128);
    setrow(CUR, -50, 7, 33, -128, 33);
    run("t5", 1'b0, 10, 46, 2);
    setrow(CUR, -100, -100, -90, -100, -100);
    run("t6", 1'b0, 0, 46, 2);
    chk("t6_avg3", {23'b0, mem[3]}, {23'b0, 9'h1de});
    setrow(CUR, 1, 2, 3, 4, 5);
    hn = 0;
    run("t7", 1'b1, 0, 36, 4);
    setrow(CUR, 0, 0, 0, 9, 0);
    @(negedge clk);
    model(2);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    chk("mid_rst_stage", {29'b0, sleep_stage}, 32'd0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_done", {31'b0, done}, 32'd0);
    hn = 0;
    run("t8", 1'b0, 0, 36, 3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
